// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator ALU: the operation encoding and the datapath sizes.
package pkg;

   localparam int DATA_W   = 8;
   localparam int NUM_REGS = 3;

   // All 16 encodings are legal, so incrementing past LOAD wraps back to ADD.
   typedef enum logic [3:0] {
      ADD  = 4'd0,
      SUB  = 4'd1,
      AND  = 4'd2,
      OR   = 4'd3,
      XOR  = 4'd4,
      NOT  = 4'd5,
      NAND = 4'd6,
      NOR  = 4'd7,
      XNOR = 4'd8,
      SHL  = 4'd9,
      SHR  = 4'd10,
      ROL  = 4'd11,
      ROR  = 4'd12,
      INC  = 4'd13,
      DEC  = 4'd14,
      LOAD = 4'd15
   } operation;

endpackage

// File: rtl/alu_register_file.sv
// Three operand holding registers, each loaded from the data bus, plus the operand B select mux.
import pkg::*;

module alu_register_file (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [DATA_W-1:0] i_data,
   input  logic [2:0]        i_ce,
   input  logic [3:0]        i_mux_addr,
   output logic [DATA_W-1:0] o_operand_b
);

   logic [DATA_W-1:0] r_regs [NUM_REGS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         always_ff @(posedge i_clk) begin
            if (i_rst)
               r_regs[gi] <= '0;
            else if (i_ce[gi])
               r_regs[gi] <= i_data;
         end
      end
   endgenerate

   // Reads see the pre-edge register value; a same-cycle write is not bypassed.
   always_comb begin
      o_operand_b = '0;
      case (i_mux_addr)
         4'd0:    o_operand_b = i_data;
         4'd1:    o_operand_b = r_regs[0];
         4'd2:    o_operand_b = r_regs[1];
         4'd3:    o_operand_b = r_regs[2];
         4'd4:    o_operand_b = 8'h01;
         default: o_operand_b = '0;
      endcase
   end

endmodule

// File: rtl/alu.sv
// 8-bit accumulator ALU: combines ACC with the selected operand each enabled cycle and writes back to ACC.
import pkg::*;

module alu (
   input  logic              i_clk,
   input  logic              i_rst,
   input  operation          i_operation_code,
   input  logic              i_acumulator_ce,
   input  logic [DATA_W-1:0] i_register_file,
   input  logic [2:0]        i_register_file_ce,
   input  logic [3:0]        i_register_file_mux_addr,
   output logic [DATA_W-1:0] o_acumulator
);

   logic [DATA_W-1:0] r_acc;
   logic [DATA_W-1:0] w_b;
   logic [DATA_W-1:0] w_result;

   alu_register_file u_register_file (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_data      (i_register_file),
      .i_ce        (i_register_file_ce),
      .i_mux_addr  (i_register_file_mux_addr),
      .o_operand_b (w_b)
   );

   // Arithmetic wraps modulo 256; carries and borrows are simply dropped.
   always_comb begin
      w_result = r_acc;
      case (i_operation_code)
         ADD:  w_result = r_acc + w_b;
         SUB:  w_result = r_acc - w_b;
         AND:  w_result = r_acc & w_b;
         OR:   w_result = r_acc | w_b;
         XOR:  w_result = r_acc ^ w_b;
         NOT:  w_result = ~r_acc;
         NAND: w_result = ~(r_acc & w_b);
         NOR:  w_result = ~(r_acc | w_b);
         XNOR: w_result = ~(r_acc ^ w_b);
         SHL:  w_result = {r_acc[6:0], 1'b0};
         SHR:  w_result = {1'b0, r_acc[7:1]};
         ROL:  w_result = {r_acc[6:0], r_acc[7]};
         ROR:  w_result = {r_acc[0], r_acc[7:1]};
         INC:  w_result = r_acc + 8'd1;
         DEC:  w_result = r_acc - 8'd1;
         LOAD: w_result = w_b;
         default: w_result = r_acc;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_acc <= '0;
      else if (i_acumulator_ce)
         r_acc <= w_result;
   end

   assign o_acumulator = r_acc;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed and random stimulus, arithmetic reference model, queue-based scoreboard.
import pkg::*;

module tb_alu;

   logic       clk = 1'b0;
   logic       rst;
   operation   op_code;
   logic       acc_ce;
   logic [7:0] bus;
   logic [2:0] rf_ce;
   logic [3:0] mux;
   logic [7:0] acc_out;

   typedef struct {
      string name;
      int    exp;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // reference model state
   int m_acc = 0;
   int m_r[3] = '{0, 0, 0};

   always #5 clk = ~clk;

   alu dut (
      .i_clk                    (clk),
      .i_rst                    (rst),
      .i_operation_code         (op_code),
      .i_acumulator_ce          (acc_ce),
      .i_register_file          (bus),
      .i_register_file_ce       (rf_ce),
      .i_register_file_mux_addr (mux),
      .o_acumulator             (acc_out)
   );

   function automatic int model_f(input int o, input int a, input int b);
      case (o)
         0:  return (a + b) % 256;
         1:  return (a - b + 256) % 256;
         2:  return a & b;
         3:  return a | b;
         4:  return a ^ b;
         5:  return 255 - a;
         6:  return 255 - (a & b);
         7:  return 255 - (a | b);
         8:  return 255 - (a ^ b);
         9:  return (a * 2) % 256;
         10: return a / 2;
         11: return (a * 2) % 256 + a / 128;
         12: return a / 2 + (a % 2) * 128;
         13: return (a + 1) % 256;
         14: return (a + 255) % 256;
         default: return b;
      endcase
   endfunction

   task automatic step(input logic r, input int o, input logic ce, input int d,
                       input int wce, input int m, input string name);
      int b;
      exp_t e;
      @(negedge clk);
      rst     = r;
      op_code = operation'(o[3:0]);
      acc_ce  = ce;
      bus     = d[7:0];
      rf_ce   = wce[2:0];
      mux     = m[3:0];
      if (m == 0)      b = d;
      else if (m <= 3) b = m_r[m-1];
      else if (m == 4) b = 1;
      else             b = 0;
      if (r) begin
         m_acc = 0;
         for (int k = 0; k < 3; k++) m_r[k] = 0;
      end else begin
         if (ce) m_acc = model_f(o, m_acc, b);
         for (int k = 0; k < 3; k++) if (wce[k]) m_r[k] = d;
      end
      e.name = name;
      e.exp  = m_acc;
      sb.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (int'(acc_out) != e.exp) begin
               bad++;
               $display("FAIL %s: acc got=%02h want=%02h", e.name, acc_out, e.exp[7:0]);
            end else begin
               $display("ok   %s: acc=%02h", e.name, acc_out);
            end
         end
      end
   end

   initial begin : driver
      rst = 1'b1; op_code = ADD; acc_ce = 1'b0; bus = 8'd5; rf_ce = 3'b000; mux = 4'd0;

      step(1, 0, 0, 5, 0, 0, "reset");
      step(0, 0, 1, 5, 0, 0, "add1");
      step(0, 0, 1, 5, 0, 0, "add2");
      step(0, 1, 1, 5, 0, 0, "sub");

      for (int o = 0; o < 16; o++) begin
         step(0, 15, 1, 5, 0, 0, "sweep_load");
         step(0, o, 1, 5, 0, 0, $sformatf("sweep_op%0d", o));
      end

      step(0, 15, 1, 8'h00, 0, 0, "load00");
      step(0, 14, 1, 8'h00, 0, 0, "dec_wrap");
      step(0, 13, 1, 8'h00, 0, 0, "inc_wrap");

      step(0, 15, 1, 8'h5A, 0, 0, "load5a");
      step(0, 4,  1, 8'hFF, 0, 0, "xor_ff");
      step(0, 15, 1, 8'h81, 0, 0, "load81");
      step(0, 11, 1, 8'h00, 0, 0, "rol");
      step(0, 15, 1, 8'h81, 0, 0, "load81");
      step(0, 12, 1, 8'h00, 0, 0, "ror");
      step(0, 15, 1, 8'h81, 0, 0, "load81");
      step(0, 10, 1, 8'h00, 0, 0, "shr");

      step(0, 15, 0, 8'h33, 3'b010, 0, "wr_r1");
      step(0, 15, 1, 8'h0F, 0, 2, "load_r1");
      step(0, 15, 1, 8'h44, 3'b010, 2, "wr_rd_r1_old");
      step(0, 15, 1, 8'h00, 0, 2, "rd_r1_new");
      step(0, 15, 1, 8'h00, 0, 4, "mux4_const");
      step(0, 15, 1, 8'h77, 0, 9, "mux9_zero");

      step(0, 15, 1, 8'hC3, 0, 0, "load_c3");
      for (int i = 0; i < 5; i++)
         step(0, i * 3 + 1, 0, $urandom_range(0, 255), 0, 0, "frozen");

      step(0, 15, 1, 8'h9A, 3'b111, 0, "fill_regs");
      step(1, 0, 1, 8'hEE, 3'b111, 0, "mid_reset");
      step(0, 15, 1, 8'hEE, 0, 1, "r0_after_rst");
      step(0, 15, 1, 8'hEE, 0, 2, "r1_after_rst");
      step(0, 15, 1, 8'hEE, 0, 3, "r2_after_rst");

      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 49) == 0), $urandom_range(0, 15), ($urandom_range(0, 3) != 0),
              $urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 15), "random");

      @(negedge clk);
      rst = 1'b0; acc_ce = 1'b0; rf_ce = 3'b000;
      repeat (4) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: pending got=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu.md
# alu

8-bit accumulator ALU with a small operand register file, used as the datapath core of the team's simple processor. Each enabled clock cycle it combines the accumulator with a selected 8-bit operand under a 4-bit operation code and writes the result back to the accumulator. The operand comes either directly from the input bus or from one of three internal holding registers loaded from that bus.

## Interface
- Parameters: none; data width fixed at 8 bits.
- i_clk  in  1  system clock, all state on rising edge.
- i_rst  in  1  reset; one clock; reset is synchronous and active-high.
- i_operation_code  in  operation (4)  operation select, enum from pkg.
- i_acumulator_ce  in  1  accumulator clock enable.
- i_register_file  in  8  data bus; direct operand and register-file write data.
- i_register_file_ce  in  3  one-hot-capable write enables; bit k loads R[k].
- i_register_file_mux_addr  in  4  operand B select.
- o_acumulator  out  8  accumulator contents (registered).

## Operation
- State: ACC[7:0], R0..R2[7:0].
- Register file: for each k, if i_register_file_ce[k] then R[k] <= i_register_file; several bits may be set at once.
- Operand B mux: 0 -> i_register_file; 1/2/3 -> R0/R1/R2; 4 -> 8'h01; 5..15 -> 8'h00.
- When i_acumulator_ce = 1, ACC <= f(ACC, B); else ACC holds.
- Opcodes: ADD(0) A+B; SUB(1) A-B; AND(2); OR(3); XOR(4); NOT(5) ~A; NAND(6); NOR(7); XNOR(8); SHL(9) A<<1, LSB 0; SHR(10) A>>1 logical, MSB 0; ROL(11) {A[6:0],A[7]}; ROR(12) {A[0],A[7:1]}; INC(13) A+1; DEC(14) A-1; LOAD(15) B.
- Arithmetic is modulo 256; carry/borrow discarded, no flags.
- Unary ops (NOT, shifts, rotates, INC, DEC) ignore B.

## Timing
- Reset: on rising edge with i_rst = 1, ACC and R0..R2 become 8'h00; reset overrides all enables.
- o_acumulator is a direct register output; a result appears 1 cycle after the edge sampling the inputs.
- Operand reads use register values before the edge: writing R[k] and selecting R[k] in the same cycle uses the old R[k]. No bypass.
- Register-file writes proceed regardless of i_acumulator_ce.
- Reset mid-sequence: next cycle ACC = 0, and operation resumes from 0.
- i_acumulator_ce = 0: ACC frozen for any opcode.

## Structure
- Shared package pkg: typedef enum logic [3:0] operation {ADD, SUB, AND, OR, XOR, NOT, NAND, NOR, XNOR, SHL, SHR, ROL, ROR, INC, DEC, LOAD} with encodings 0..15 in that order. All 16 codes are legal, so incrementing past LOAD wraps to ADD.
- Sub-module alu_register_file: holds R0..R2 and the operand B mux. The top level holds the combinational function unit and the ACC register.

## Test plan
- Reset with i_register_file = 8'd5 and mux = 0 -> o_acumulator = 0. ADD for one enabled cycle -> 5; second ADD -> 10; SUB -> 5.
- Sweep: from ACC = 0x05 with B = 5, step the opcode each cycle ADD..LOAD -> each result matches the function table. Check wrap-around cases: DEC of 0x00 = 0xFF, and INC of 0xFF = 0x00.
- LOAD 0x5A, then XOR with B = 0xFF -> 0xA5. Load 0x81, then ROL -> 0x03; load 0x81, then ROR -> 0xC0; load 0x81, then SHR -> 0x40.
- Write 0x33 to R1 (ce = 3'b010), then 0x0F to the bus, mux = 2, LOAD -> ACC = 0x33. Same-cycle write and read of R1 -> old value used.
- With ce = 0, toggle opcodes for 5 cycles -> ACC unchanged. Then assert i_rst mid-stream -> ACC = 0x00 and R0..R2 read back 0x00 next cycle.
